// File: rtl/filter_sample_driver_if.sv
// Sample/filter/result handshake bundle for filter_sample_driver.
// master is the driver side; slave is the source/filter/sink side.
interface filter_sample_driver_if #(
  parameter int DW = 32
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flt_ready;
  logic          flt_valid;
  logic [DW-1:0] flt_y;
  logic          flt_start;
  logic [DW-1:0] flt_x;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    input  in_data, in_valid, flt_ready, flt_valid, flt_y, out_ready,
    output in_ready, flt_start, flt_x, out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, flt_ready, flt_valid, flt_y, out_ready,
    input  in_ready, flt_start, flt_x, out_data, out_valid
  );
endinterface

// File: rtl/filter_sample_driver.sv
// Buffers upstream samples in a FIFO, issues them one at a time to the FIR core,
// and holds each result on a valid/ready output with a watchdog on the core.
module filter_sample_driver #(
  parameter int DW      = 32,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  filter_sample_driver_if.master bus,
  output logic                   busy,
  output logic [15:0]            result_cnt,
  output logic                   timeout_err
);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES} state_e;

  state_e        state_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  logic          valid_q, result_edge;
  logic [WW-1:0] wd_q, wd_d;
  logic          flt_start_q;
  logic [DW-1:0] flt_x_q, out_data_q;
  logic          out_valid_q;
  logic [15:0]   result_cnt_q;
  logic          timeout_err_q;

  assign full        = (count_q == (AW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign push        = bus.in_valid && !full;
  assign pop         = (state_q == IDLE) && !empty && bus.flt_ready && !out_valid_q;
  assign result_edge = bus.flt_valid && !valid_q;
  assign wd_d        = wd_q + 1'b1;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (!push && pop)
      count_d = count_q - 1'b1;
  end

  // Storage is left unreset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // The head is popped and latched into flt_x on the edge entering ISSUE,
  // so flt_start and flt_x are both registered and valid throughout ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      flt_start_q   <= 1'b0;
      flt_x_q       <= '0;
      wd_q          <= '0;
      valid_q       <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      result_cnt_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      valid_q <= bus.flt_valid;
      if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q     <= ISSUE;
            flt_start_q <= 1'b1;
            flt_x_q     <= mem_q[rd_ptr_q];
          end
        end
        ISSUE: begin
          flt_start_q <= 1'b0;
          wd_q        <= '0;
          state_q     <= WAIT_RES;
        end
        WAIT_RES: begin
          wd_q <= wd_d;
          // Only a fresh rising edge counts; a level left over from the previous result is ignored.
          if (result_edge) begin
            out_data_q   <= bus.flt_y;
            out_valid_q  <= 1'b1;
            result_cnt_q <= result_cnt_q + 1'b1;
            state_q      <= IDLE;
          end else if (wd_d == WW'(TIMEOUT)) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !full;
  assign bus.flt_start = flt_start_q;
  assign bus.flt_x     = flt_x_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = (state_q != IDLE);
  assign result_cnt    = result_cnt_q;
  assign timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_filter_sample_driver.sv
// Directed bench for filter_sample_driver with a behavioural FIR-core model
// that answers each start after a programmable delay, or never.
module tb_filter_sample_driver;
  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] result_cnt;
  logic        timeout_err;

  int passCount = 0;
  int checkCount = 0;
  int startCount = 0;
  logic [31:0] startX[$];

  int          modelDelay = 60;
  logic [31:0] modelY = 32'h4000_0000;
  bit          modelSilent = 1'b0;

  filter_sample_driver_if #(.DW(32)) bus ();

  filter_sample_driver dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .result_cnt (result_cnt),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Filter core model and start monitor, both acting on the falling edge.
  initial begin : filterModel
    int cnt;
    bit active;
    cnt = 0;
    active = 1'b0;
    bus.flt_valid = 1'b0;
    bus.flt_y = '0;
    forever begin
      @(negedge clk);
      if (bus.flt_start) begin
        startCount++;
        startX.push_back(bus.flt_x);
        bus.flt_valid = 1'b0;
        active = !modelSilent;
        cnt = modelDelay;
      end else if (active) begin
        cnt--;
        if (cnt <= 0) begin
          bus.flt_valid = 1'b1;
          bus.flt_y = modelY;
          active = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] data);
    bus.in_data = data;
    bus.in_valid = 1'b1;
    tick(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulseOutReady();
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
  endtask

  task automatic waitOutValid(input string tag, input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic waitStarts(input string tag, input int target, input int budget);
    int n = 0;
    while (startCount < target && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, startCount, target);
  endtask

  task automatic waitResults(input string tag, input int target, input int budget);
    int n = 0;
    while (int'(result_cnt) < target && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, {16'd0, result_cnt}, target);
  endtask

  initial begin
    int sc;
    rst = 1'b1;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.flt_ready = 1'b1;
    bus.out_ready = 1'b0;
    tick(2);
    rst = 1'b0;

    tick(10);
    checkOutput("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("idle_starts", startCount, 0);
    checkOutput("idle_result_cnt", {16'd0, result_cnt}, 32'd0);
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_flt_x", bus.flt_x, 32'd0);
    checkOutput("idle_out_data", bus.out_data, 32'd0);
    checkOutput("idle_timeout", {31'd0, timeout_err}, 32'd0);

    // Single sample: start one cycle after the FIFO write edge's decision.
    applyStimulus(32'h3F80_0000);
    tick(1);
    checkOutput("single_start", {31'd0, bus.flt_start}, 32'd1);
    checkOutput("single_flt_x", bus.flt_x, 32'h3F80_0000);
    checkOutput("single_busy", {31'd0, busy}, 32'd1);
    tick(1);
    checkOutput("single_start_pulse", {31'd0, bus.flt_start}, 32'd0);
    waitOutValid("single_wait_result", 200);
    checkOutput("single_out_data", bus.out_data, 32'h4000_0000);
    checkOutput("single_result_cnt", {16'd0, result_cnt}, 32'd1);
    checkOutput("single_start_count", startCount, 1);
    checkOutput("single_flt_x_hold", bus.flt_x, 32'h3F80_0000);
    tick(5);
    checkOutput("single_out_held", {31'd0, bus.out_valid}, 32'd1);
    pulseOutReady();
    checkOutput("single_out_cleared", {31'd0, bus.out_valid}, 32'd0);

    // Fill the FIFO with the filter stalled; the ninth sample is refused.
    bus.flt_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 8) checkOutput("fifo_ready_at_7", {31'd0, bus.in_ready}, 32'd1);
      if (i == 9) checkOutput("fifo_full_at_8", {31'd0, bus.in_ready}, 32'd0);
      applyStimulus(i);
    end
    tick(3);
    checkOutput("fifo_no_start", startCount, 1);
    checkOutput("fifo_idle_busy", {31'd0, busy}, 32'd0);
    modelDelay = 3;
    modelY = 32'h1111_1111;
    bus.out_ready = 1'b1;
    bus.flt_ready = 1'b1;
    waitStarts("fifo_drain_starts", 9, 400);
    waitResults("fifo_drain_results", 9, 400);
    tick(10);
    checkOutput("fifo_ninth_refused", startCount, 9);
    for (int i = 1; i <= 8; i++) checkOutput($sformatf("fifo_order_%0d", i), startX[i], i);
    checkOutput("fifo_ready_again", {31'd0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b0;

    // Pending output blocks further issues until it is accepted.
    modelY = 32'h2222_2222;
    applyStimulus(32'h0000_00A1);
    applyStimulus(32'h0000_00A2);
    applyStimulus(32'h0000_00A3);
    waitOutValid("hold_first_result", 100);
    tick(20);
    checkOutput("hold_no_second_start", startCount, 10);
    checkOutput("hold_out_data", bus.out_data, 32'h2222_2222);
    pulseOutReady();
    tick(1);
    checkOutput("hold_next_start", {31'd0, bus.flt_start}, 32'd1);
    checkOutput("hold_next_flt_x", bus.flt_x, 32'h0000_00A2);
    waitOutValid("hold_second_result", 100);
    pulseOutReady();
    waitOutValid("hold_third_result", 100);
    checkOutput("hold_third_x", startX[11], 32'h0000_00A3);
    pulseOutReady();
    checkOutput("hold_result_cnt", {16'd0, result_cnt}, 32'd12);

    // Silent filter: watchdog aborts 255 cycles after ISSUE, next sample still runs.
    modelSilent = 1'b1;
    modelY = 32'h3333_3333;
    applyStimulus(32'h0000_00B1);
    applyStimulus(32'h0000_00B2);
    checkOutput("wd_start", {31'd0, bus.flt_start}, 32'd1);
    checkOutput("wd_flt_x", bus.flt_x, 32'h0000_00B1);
    tick(255);
    checkOutput("wd_not_yet", {31'd0, timeout_err}, 32'd0);
    checkOutput("wd_still_busy", {31'd0, busy}, 32'd1);
    tick(1);
    modelSilent = 1'b0;
    checkOutput("wd_timeout", {31'd0, timeout_err}, 32'd1);
    checkOutput("wd_back_idle", {31'd0, busy}, 32'd0);
    tick(1);
    checkOutput("wd_next_start", {31'd0, bus.flt_start}, 32'd1);
    checkOutput("wd_next_flt_x", bus.flt_x, 32'h0000_00B2);
    waitOutValid("wd_next_result", 100);
    checkOutput("wd_result_cnt", {16'd0, result_cnt}, 32'd13);
    checkOutput("wd_out_data", bus.out_data, 32'h3333_3333);
    pulseOutReady();
    tick(5);
    checkOutput("wd_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset while waiting on a result with four samples queued.
    modelDelay = 60;
    for (int i = 1; i <= 5; i++) applyStimulus(32'h0000_00C0 + i);
    tick(5);
    checkOutput("rst_busy_before", {31'd0, busy}, 32'd1);
    checkOutput("rst_queued", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_flt_start", {31'd0, bus.flt_start}, 32'd0);
    checkOutput("rst_flt_x", bus.flt_x, 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    checkOutput("rst_result_cnt", {16'd0, result_cnt}, 32'd0);
    checkOutput("rst_timeout", {31'd0, timeout_err}, 32'd0);
    sc = startCount;
    tick(80);
    checkOutput("rst_late_edge_flt_valid", {31'd0, bus.flt_valid}, 32'd1);
    checkOutput("rst_no_more_starts", startCount, sc);
    checkOutput("rst_late_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_late_result_cnt", {16'd0, result_cnt}, 32'd0);
    checkOutput("rst_late_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
